lt100_timer: RTL and testbench

- Memory-mapped timer/compare peripheral that acts as a *responder* on the lt100 CPU bus (the CPU is the initiator).
- Decodes its address window and services single-word reads and byte-enabled writes with the enable/ready handshake.
- Runs a prescaled 32-bit up-counter with compare and overflow flags, and drives a level irq into the lt100_bus irq aggregation.

---
 rtl/lt100_timer_pkg.sv | 38 +++
 rtl/lt100_prescaler.sv | 35 +++
 rtl/lt100_timer.sv | 221 ++++++++++++++++++++++
 tb/tb_lt100_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lt100_timer_pkg.sv
// Shared constants for the lt100 timer/compare peripheral: register offsets,
// CTRL/STATUS bit positions, responder FSM encoding and a byte-lane merge helper.
package lt100_timer_pkg;

   localparam logic [7:0] TMR_CTRL     = 8'h00;
   localparam logic [7:0] TMR_PRESCALE = 8'h04;
   localparam logic [7:0] TMR_COUNT    = 8'h08;
   localparam logic [7:0] TMR_COMPARE  = 8'h0C;
   localparam logic [7:0] TMR_STATUS   = 8'h10;

   localparam int CTRL_RUN        = 0;
   localparam int CTRL_IRQ_EN     = 1;
   localparam int CTRL_AUTORELOAD = 2;
   localparam int STAT_MATCH      = 0;
   localparam int STAT_OVF        = 1;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_ACK  = 1'b1
   } tmr_state_e;

   // Replace only the byte lanes selected by be, keep the rest of the old word.
   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/lt100_prescaler.sv
// Prescale counter for lt100_timer: counts 0..i_prescale while running and
// emits a one-cycle tick on the wrap; i_clr restarts the count from zero.
module lt100_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_run,
   input  logic                  i_clr,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] r_cnt;

   // Prescale count register: clear has priority, otherwise count while running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_run) begin
         if (r_cnt == i_prescale) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_tick = i_run & (r_cnt == i_prescale);

endmodule

// File: rtl/lt100_timer.sv
// lt100 bus responder with a prescaled 32-bit compare/overflow timer.
// Optional build macro LT100_TIMER_AUTORELOAD_EN makes CTRL[2] reload COUNT on match.
module lt100_timer
   import lt100_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0100,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] i_data,
   input  logic [3:0]  be,
   output logic        ready,
   output logic [31:0] o_data,
   output logic        bus_err,
   output logic        irq,
   output logic        sel
);

`ifdef LT100_TIMER_AUTORELOAD_EN
   localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
   localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

   tmr_state_e            r_state;
   tmr_state_e            w_state_nxt;
   logic [2:0]            r_ctrl;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic [1:0]            r_status;
   logic                  r_ready;
   logic [31:0]           r_o_data;
   logic                  r_bus_err;
   logic                  r_irq;
   logic                  r_sel;

   logic [7:0]  w_off;
   logic        w_hit;
   logic        w_err;
   logic        w_accept;
   logic        w_do_wr;
   logic [31:0] w_rdata;
   logic [31:0] w_wmerge;
   logic [1:0]  w_w1c;
   logic        w_tick;
   logic        w_match_set;
   logic        w_ovf_set;

   assign w_off       = addr[7:0];
   assign w_hit       = (addr[31:8] == BASE_ADDR[31:8]);
   assign w_err       = (addr[1:0] != 2'b00) | (w_off > TMR_STATUS);
   assign w_accept    = (r_state == TMR_IDLE) & enable & w_hit;
   assign w_do_wr     = w_accept & wr_en & ~w_err;
   assign w_wmerge    = be_merge(w_rdata, i_data, be);
   assign w_w1c       = (w_do_wr && (w_off == TMR_STATUS) && be[0]) ? i_data[1:0] : 2'b00;
   assign w_match_set = w_tick & (r_count == r_compare);
   assign w_ovf_set   = w_tick & (r_count == 32'hFFFF_FFFF);

   lt100_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .i_run      (r_ctrl[CTRL_RUN]),
      .i_clr      (w_do_wr && (w_off == TMR_PRESCALE)),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );

   // Current value of the addressed register; also the base for byte-masked writes.
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (w_off)
         TMR_CTRL:     w_rdata = {29'h0000_0000, r_ctrl};
         TMR_PRESCALE: w_rdata = 32'(r_prescale);
         TMR_COUNT:    w_rdata = r_count;
         TMR_COMPARE:  w_rdata = r_compare;
         TMR_STATUS:   w_rdata = {30'h0000_0000, r_status};
         default:      w_rdata = 32'h0000_0000;
      endcase
   end

   // Responder FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= TMR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Responder FSM next state: ACK is left only once the initiator drops enable.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TMR_IDLE: begin
            if (w_accept) begin
               w_state_nxt = TMR_ACK;
            end else begin
               w_state_nxt = TMR_IDLE;
            end
         end
         TMR_ACK: begin
            if (!enable) begin
               w_state_nxt = TMR_IDLE;
            end else begin
               w_state_nxt = TMR_ACK;
            end
         end
         default: w_state_nxt = TMR_IDLE;
      endcase
   end

   // Bus response registers, held stable for the whole ACK phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready   <= 1'b0;
         r_sel     <= 1'b0;
         r_bus_err <= 1'b0;
         r_o_data  <= 32'h0000_0000;
      end else begin
         case (r_state)
            TMR_IDLE: begin
               if (w_accept) begin
                  r_ready   <= 1'b1;
                  r_sel     <= 1'b1;
                  r_bus_err <= w_err;
                  r_o_data  <= (wr_en || w_err) ? 32'h0000_0000 : w_rdata;
               end else begin
                  r_ready   <= r_ready;
                  r_sel     <= r_sel;
                  r_bus_err <= r_bus_err;
                  r_o_data  <= r_o_data;
               end
            end
            TMR_ACK: begin
               if (!enable) begin
                  r_ready   <= 1'b0;
                  r_sel     <= 1'b0;
                  r_bus_err <= 1'b0;
                  r_o_data  <= 32'h0000_0000;
               end else begin
                  r_ready   <= r_ready;
                  r_sel     <= r_sel;
                  r_bus_err <= r_bus_err;
                  r_o_data  <= r_o_data;
               end
            end
            default: begin
               r_ready   <= 1'b0;
               r_sel     <= 1'b0;
               r_bus_err <= 1'b0;
               r_o_data  <= 32'h0000_0000;
            end
         endcase
      end
   end

   // Configuration registers written by the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl     <= 3'b000;
         r_prescale <= '0;
         r_compare  <= 32'h0000_0000;
      end else begin
         if (w_do_wr && (w_off == TMR_CTRL)) begin
            r_ctrl <= w_wmerge[2:0] & CTRL_WMASK;
         end else begin
            r_ctrl <= r_ctrl;
         end
         if (w_do_wr && (w_off == TMR_PRESCALE)) begin
            r_prescale <= w_wmerge[PRESCALE_W-1:0];
         end else begin
            r_prescale <= r_prescale;
         end
         if (w_do_wr && (w_off == TMR_COMPARE)) begin
            r_compare <= w_wmerge;
         end else begin
            r_compare <= r_compare;
         end
      end
   end

   // COUNT: a bus write beats a same-cycle tick; match optionally reloads to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 32'h0000_0000;
      end else if (w_do_wr && (w_off == TMR_COUNT)) begin
         r_count <= w_wmerge;
      end else if (w_tick) begin
         if (r_ctrl[CTRL_AUTORELOAD] && w_match_set) begin
            r_count <= 32'h0000_0000;
         end else begin
            r_count <= r_count + 32'h0000_0001;
         end
      end else begin
         r_count <= r_count;
      end
   end

   // STATUS flags (a set wins over a same-cycle clear) and the registered irq.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= 2'b00;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_w1c) | {w_ovf_set, w_match_set};
         r_irq    <= r_ctrl[CTRL_IRQ_EN] & (r_status[STAT_MATCH] | r_status[STAT_OVF]);
      end
   end

   assign ready   = r_ready;
   assign o_data  = r_o_data;
   assign bus_err = r_bus_err;
   assign irq     = r_irq;
   assign sel     = r_sel;

endmodule

// File: tb/tb_lt100_timer.sv
// Directed bench for lt100_timer: bus transfers with a response scoreboard,
// timer compare/overflow timing, error responses and mid-transaction reset.
module tb_lt100_timer;

   localparam logic [31:0] BASE = 32'h4000_0100;
`ifdef LT100_TIMER_AUTORELOAD_EN
   localparam logic [31:0] CTRL_ALL = 32'h0000_0007;
`else
   localparam logic [31:0] CTRL_ALL = 32'h0000_0003;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] i_data;
   logic [3:0]  be;
   logic        ready;
   logic [31:0] o_data;
   logic        bus_err;
   logic        irq;
   logic        sel;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   lt100_timer dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wr_en   (wr_en),
      .addr    (addr),
      .i_data  (i_data),
      .be      (be),
      .ready   (ready),
      .o_data  (o_data),
      .bus_err (bus_err),
      .irq     (irq),
      .sel     (sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transfer; enable is held 'hold' extra cycles after ready to check stability.
   task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_d, input logic exp_e, input int hold);
      exp_t e;
      int   n;
      e.data = exp_d;
      e.err  = exp_e;
      sb.push_back(e);
      @(negedge clk);
      enable = 1'b1; wr_en = w; addr = a; i_data = d; be = b;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready && n < 8);
      check({tag, "_lat"}, 32'(n), 32'd1);
      e = sb.pop_front();
      check({tag, "_data"}, o_data, e.data);
      check({tag, "_err"}, {31'd0, bus_err}, {31'd0, e.err});
      check({tag, "_sel"}, {31'd0, sel}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_rdy"}, {31'd0, ready}, 32'd1);
         check({tag, "_hold_data"}, o_data, e.data);
      end
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rdy_fall"}, {31'd0, ready}, 32'd0);
      check({tag, "_data_clr"}, o_data, 32'd0);
   endtask

   task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] d, input logic [3:0] b);
      xfer(tag, 1'b1, BASE + 32'(off), d, b, 32'd0, 1'b0, 0);
   endtask

   task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp_d);
      xfer(tag, 1'b0, BASE + 32'(off), 32'd0, 4'b0000, exp_d, 1'b0, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; enable = 1'b0; wr_en = 1'b0; addr = 32'd0; i_data = 32'd0; be = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_err", {31'd0, bus_err}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_sel", {31'd0, sel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // COMPARE write/readback, with enable held to prove the response is stable
      wr("cmp_wr", 8'h0C, 32'h0000_0005, 4'b1111);
      xfer("cmp_rd", 1'b0, BASE + 32'h0C, 32'd0, 4'b0000, 32'h0000_0005, 1'b0, 2);

      // CTRL byte enables: only bits [1:0] (or [2:0]) exist; be=0 writes nothing
      wr("ctrl_wr", 8'h00, 32'hFFFF_FFFF, 4'b0001);
      rd("ctrl_rd", 8'h00, CTRL_ALL);
      wr("ctrl_be0", 8'h00, 32'h0000_0000, 4'b0000);
      rd("ctrl_rd2", 8'h00, CTRL_ALL);
      wr("ctrl_stop", 8'h00, 32'h0000_0000, 4'b1111);

      // Compare match: PRESCALE=2, COMPARE=3; match on the 4th tick, irq one cycle later
      wr("m_pre", 8'h04, 32'h0000_0002, 4'b1111);
      wr("m_cnt", 8'h08, 32'h0000_0000, 4'b1111);
      wr("m_cmp", 8'h0C, 32'h0000_0003, 4'b1111);
      wr("m_clr", 8'h10, 32'h0000_0003, 4'b0001);
      check("m_irq_pre", {31'd0, irq}, 32'd0);
      wr("m_run", 8'h00, 32'h0000_0003, 4'b1111);
      // run becomes active at the CTRL accept edge A; ticks at A+3k, the 4th at A+12
      // sets match and irq follows at A+13, i.e. the 12th edge polled from A+2.
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!irq && n < 40);
      check("m_irq_cycle", 32'(n), 32'd12);
      rd("m_stat", 8'h10, 32'h0000_0001);
      wr("m_w1c", 8'h10, 32'h0000_0001, 4'b0001);
      check("m_irq_drop", {31'd0, irq}, 32'd0);
      wr("m_stop", 8'h00, 32'h0000_0000, 4'b1111);

      // Overflow with a W1C landing on the same edge as the ovf set
      wr("o_pre", 8'h04, 32'h0000_0000, 4'b1111);
      wr("o_cmp", 8'h0C, 32'h0000_1000, 4'b1111);
      wr("o_cnt", 8'h08, 32'hFFFF_FFFE, 4'b1111);
      wr("o_clr", 8'h10, 32'h0000_0003, 4'b0001);
      wr("o_run", 8'h00, 32'h0000_0001, 4'b1111);
      // Accept edge A: tick at A+1 (->FFFF_FFFF), A+2 (->0, ovf) coincides with this W1C,
      // A+3 (->1); the COUNT read is accepted at A+4 and sees 1.
      wr("o_w1c", 8'h10, 32'h0000_0002, 4'b0001);
      rd("o_cnt_rd", 8'h08, 32'h0000_0001);
      rd("o_stat", 8'h10, 32'h0000_0002);
      wr("o_stop", 8'h00, 32'h0000_0000, 4'b1111);

      // Error responses and no side effect of an erroneous write
      xfer("e_off14", 1'b0, BASE + 32'h14, 32'd0, 4'b0000, 32'd0, 1'b1, 0);
      xfer("e_unal", 1'b0, 32'h4000_0102, 32'd0, 4'b0000, 32'd0, 1'b1, 0);
      xfer("e_wr", 1'b1, BASE + 32'h0D, 32'hAAAA_AAAA, 4'b1111, 32'd0, 1'b1, 0);
      rd("e_cmp", 8'h0C, 32'h0000_1000);

      // Window miss: no response at all
      @(negedge clk);
      enable = 1'b1; wr_en = 1'b0; addr = 32'h4000_0200; be = 4'b0000;
      repeat (4) @(posedge clk);
      #1;
      check("miss_ready", {31'd0, ready}, 32'd0);
      check("miss_sel", {31'd0, sel}, 32'd0);
      @(negedge clk);
      enable = 1'b0;

      // Reset while in ACK drops ready at once; state returns to zero
      @(negedge clk);
      enable = 1'b1; wr_en = 1'b0; addr = BASE + 32'h08;
      @(posedge clk); #1;
      check("ra_ready", {31'd0, ready}, 32'd1);
      rst = 1'b1;
      #1;
      check("ra_ready_rst", {31'd0, ready}, 32'd0);
      check("ra_sel_rst", {31'd0, sel}, 32'd0);
      @(negedge clk);
      enable = 1'b0;
      rst = 1'b0;
      rd("ra_cnt", 8'h08, 32'h0000_0000);
      rd("ra_ctrl", 8'h00, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
